// File: rtl/instr_encoder.sv
// Instruction encoder: packs R-type and immediate operations into 32-bit words,
// buffers them in a 4-entry FIFO and presents them with an auto-incrementing address.
module instr_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic        addr_load,
  input  logic [7:0]  addr_base,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [7:0]  instr_addr,
  output logic [8:0]  instr_count
);

  function automatic logic [31:0] encode_word(input logic [2:0] sel, input logic [4:0] f_rs,
                                              input logic [4:0] f_rt, input logic [4:0] f_rd,
                                              input logic [15:0] f_imm);
    logic [31:0] w;
    case (sel)
      3'd0:    w = {6'b000001, 5'd0, 5'd0, 5'd0, 5'd10, 6'd31};
      3'd1:    w = {6'b000001, f_rs, f_rt, f_rd, 5'd10, 6'd32};
      3'd2:    w = {6'b000001, f_rs, f_rt, f_rd, 5'd10, 6'd34};
      3'd3:    w = {6'b000001, f_rs, f_rt, f_rd, 5'd10, 6'd36};
      3'd4:    w = {6'b000001, f_rs, f_rt, f_rd, 5'd10, 6'd37};
      3'd5:    w = {6'b000001, f_rs, f_rt, f_rd, 5'd10, 6'd50};
      3'd6:    w = {6'b000010, f_rs, f_rt, f_imm};
      3'd7:    w = {6'b000011, f_rs, f_rt, f_imm};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  logic [31:0] fifo_mem_r [0:3];
  logic [1:0]  rd_ptr_r;
  logic [1:0]  wr_ptr_r;
  logic [2:0]  occ_r;
  logic [31:0] data_r;
  logic        valid_r;
  logic [7:0]  addr_r;
  logic [8:0]  count_r;

  logic        accept_s;
  logic        deliver_s;
  logic [31:0] enc_word_s;
  logic [1:0]  rd_ptr_inc_s;
  logic [2:0]  occ_nxt_s;
  logic [31:0] head_nxt_s;

  assign op_ready     = rst_n & (occ_r < 3'd4);
  assign accept_s     = op_valid & op_ready;
  assign deliver_s    = valid_r & instr_ready;
  assign enc_word_s   = encode_word(op_sel, rs, rt, rd, imm);
  assign rd_ptr_inc_s = rd_ptr_r + 2'd1;

  assign instr_valid = valid_r;
  assign instr_data  = data_r;
  assign instr_addr  = addr_r;
  assign instr_count = count_r;

  // Next occupancy and next head word, so the output word can be held in a register.
  always_comb begin
    occ_nxt_s  = occ_r;
    head_nxt_s = data_r;
    case ({accept_s, deliver_s})
      2'b10:   occ_nxt_s = occ_r + 3'd1;
      2'b01:   occ_nxt_s = occ_r - 3'd1;
      default: occ_nxt_s = occ_r;
    endcase
    if (deliver_s) begin
      // With only one word buffered, the new head can only be the word arriving now.
      if (occ_r > 3'd1) begin
        head_nxt_s = fifo_mem_r[rd_ptr_inc_s];
      end else if (accept_s) begin
        head_nxt_s = enc_word_s;
      end else begin
        head_nxt_s = data_r;
      end
    end else if ((occ_r == 3'd0) && accept_s) begin
      head_nxt_s = enc_word_s;
    end else begin
      head_nxt_s = data_r;
    end
  end

  // FIFO storage, pointers, output head register, address and delivery counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 32'd0;
      end
      rd_ptr_r <= 2'd0;
      wr_ptr_r <= 2'd0;
      occ_r    <= 3'd0;
      data_r   <= 32'd0;
      valid_r  <= 1'b0;
      addr_r   <= 8'd0;
      count_r  <= 9'd0;
    end else begin
      if (accept_s) begin
        fifo_mem_r[wr_ptr_r] <= enc_word_s;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (deliver_s) begin
        rd_ptr_r <= rd_ptr_inc_s;
      end
      occ_r   <= occ_nxt_s;
      valid_r <= (occ_nxt_s != 3'd0);
      data_r  <= head_nxt_s;
      // A load on a delivery edge overrides the increment.
      if (addr_load) begin
        addr_r <= addr_base;
      end else if (deliver_s) begin
        addr_r <= addr_r + 8'd1;
      end
      if (deliver_s && (count_r != 9'd511)) begin
        count_r <= count_r + 9'd1;
      end
    end
  end

endmodule
